rca_serial_sequencer: RTL and testbench
=======================================

Name: rca_serial_sequencer

Overview:
Multi-word addition sequencer wrapped around the team's 3-bit combinational ripple-carry adder. Accepts two WORDS×3-bit operands plus carry-in over a valid/ready handshake. Feeds the adder one 3-bit digit per cycle, LSB digit first, and registers the carry between digits. Collects the partial sums into a full-width result, presented on a valid/ready output handshake. The integration top instantiates this block next to the adder and wires the add_* ports directly.

Parameters:
WORDS, 4, number of 3-bit digits per operand (≥1); operand width W = 3*WORDS

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
in_a  in  W  operand A
in_b  in  W  operand B
in_cin  in  1  initial carry-in
add_a  out  3  digit of A to adder
add_b  out  3  digit of B to adder
add_cin  out  1  carry to adder
add_sum  in  3  adder sum (combinational return)
add_cout  in  1  adder carry-out (combinational return)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  W  result sum
out_cout  out  1  final carry-out
busy  out  1  high in RUN or DONE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, idx=0, a_reg=b_reg=sum_reg=0, carry_reg=0.
- Reset output values: out_valid=0, out_sum=0, out_cout=0, in_ready=1, busy=0, add_a=add_b=0, add_cin=0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a→a_reg, in_b→b_reg, in_cin→carry_reg; clear sum_reg; set idx=0; go to RUN.
- RUN, one digit per cycle:
  - add_a = a_reg[3*idx+:3], add_b = b_reg[3*idx+:3], add_cin = carry_reg.
  - On the clock edge: sum_reg[3*idx+:3] ← add_sum, carry_reg ← add_cout, idx++.
  - When idx==WORDS-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_cout=carry_reg.
  - Outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE the next cycle.
- add_a, add_b and add_cin are 0 outside RUN.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored; the upstream side must hold its request.
- No overlap: the next operand is accepted at the earliest one cycle after the output handshake.
- Latency: accept edge T; RUN occupies T+1..T+WORDS; out_valid is first high in cycle T+WORDS+1.
- Throughput: one result per WORDS+2 cycles under zero backpressure.
- Width rules:
  - out_sum is W bits, modulo 2^W; out_cout = bit W of A+B+cin.
  - idx width = clog2(WORDS), minimum 1.
  - WORDS=1 goes RUN→DONE after one cycle.
- Reset mid-RUN or mid-DONE: operation is aborted with no out_valid pulse; registers return to reset values next cycle.
- The adder path is combinational within the RUN cycle. The critical path is add_* → adder → sum_reg/carry_reg, i.e. a single 3-bit ripple.

Decomposition:
- Shared package rca_pkg:
  - DIGIT_W=3 constant.
  - State enum seq_state_t {IDLE, RUN, DONE}.
- No sub-module inside this block.
- The adder stays an external sibling, instantiated in the integration top; the bench reuses the same pairing.

Test Plan (WORDS=4, W=12; bench instantiates sequencer plus adder):
1. A=0x0A5, B=0x05A, cin=0, accepted at T -> out_valid first high at T+5, out_sum=0x0FF, out_cout=0; in_ready low T+1..T+5.
2. A=0xFFF, B=0x001, cin=0 -> carry ripples through all 4 digits; out_sum=0x000, out_cout=1.
3. A=0xFFF, B=0xFFF, cin=1 -> out_sum=0xFFF, out_cout=1; add_cin observed 1 in every RUN cycle.
4. Backpressure: op 0x123+0x456 cin=0, out_ready=0 for 3 cycles -> out_valid, out_sum=0x579 and out_cout=0 stay stable. A new in_valid with 0x111+0x111 during this time is not accepted (in_ready=0). Once out_ready=1, IDLE follows and the 0x111 op is then accepted and returns 0x222.
5. rst=1 in the 2nd RUN cycle -> next cycle IDLE, in_ready=1, busy=0, add_*=0, no out_valid pulse. A subsequent 0x7FF+0x001 cin=0 returns 0x800, out_cout=0.
6. Back-to-back: two ops with in_valid held high and out_ready tied 1 -> accepts are 6 cycles apart (WORDS+2), and both results are correct.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder and its multi-word sequencer.
package rca_pkg;

    localparam int unsigned DIGIT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/rca_adder3.sv
// 3-bit combinational ripple-carry adder; paired with rca_serial_sequencer at integration level.
module rca_adder3
    import rca_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/rca_serial_sequencer.sv
// Multi-word adder: streams 3-bit digits, LSB first, through an external rca_adder3 and
// collects the partial sums into a full-width result behind valid/ready handshakes.
module rca_serial_sequencer
    import rca_pkg::*;
#(
    parameter  int unsigned WORDS = 4,
    localparam int unsigned W     = DIGIT_W * WORDS,
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_cin,
    output logic [DIGIT_W-1:0] add_a,
    output logic [DIGIT_W-1:0] add_b,
    output logic               add_cin,
    input  logic [DIGIT_W-1:0] add_sum,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_sum,
    output logic               out_cout,
    output logic               busy
);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;

    int unsigned      dig_lsb;
    logic             last_digit;

    assign dig_lsb    = DIGIT_W * 32'(idx_q);
    assign last_digit = (idx_q == IDX_W'(WORDS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_q[dig_lsb +: DIGIT_W];
                add_b   = b_q[dig_lsb +: DIGIT_W];
                add_cin = carry_q;
                sum_d[dig_lsb +: DIGIT_W] = add_sum;
                carry_d = add_cout;
                if (last_digit) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = sum_q;
                out_cout  = carry_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_rca_serial_sequencer.sv
// Self-checking bench: sequencer paired with rca_adder3, checked against plain integer arithmetic.
module tb_rca_serial_sequencer;
    import rca_pkg::*;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = DIGIT_W * WORDS;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       in_a = '0;
    logic [W-1:0]       in_b = '0;
    logic               in_cin = 1'b0;
    logic [DIGIT_W-1:0] add_a, add_b, add_sum;
    logic               add_cin, add_cout;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W-1:0]       out_sum;
    logic               out_cout;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Operand presented during the DONE phase of run_op when hold_next is set.
    logic [W-1:0] next_a = '0, next_b = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    rca_serial_sequencer #(.WORDS(WORDS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    rca_adder3 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One full transaction from the current negedge (state must be IDLE); bp = cycles of
    // out_ready=0 while DONE. Returns at a negedge with the block back in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int bp, input bit hold_next);
        int unsigned full, mask, cin_i;
        full = 32'(a) + 32'(b) + 32'(cin);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = 1'b0;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            mask  = (32'd1 << (DIGIT_W * i)) - 32'd1;
            cin_i = ((32'(a) & mask) + (32'(b) & mask) + 32'(cin)) >> (DIGIT_W * i);
            check_eq("run_add_a", 32'(add_a), (32'(a) >> (DIGIT_W * i)) & 32'd7);
            check_eq("run_add_b", 32'(add_b), (32'(b) >> (DIGIT_W * i)) & 32'd7);
            check_eq("run_add_cin", 32'(add_cin), cin_i & 32'd1);
            check_eq("run_ctrl", {29'd0, in_ready, busy, out_valid}, 32'b010);
            @(negedge clk);
        end
        for (int j = 0; j <= bp; j++) begin
            check_eq("done_valid", 32'(out_valid), 32'd1);
            check_eq("done_sum", 32'(out_sum), full & ((32'd1 << W) - 32'd1));
            check_eq("done_cout", 32'(out_cout), (full >> W) & 32'd1);
            check_eq("done_ctrl", {30'd0, in_ready, busy}, 32'b01);
            check_eq("done_add_zero", {28'd0, add_a == '0, add_b == '0, add_cin, 1'b0},
                     32'b1100);
            if (hold_next) begin
                in_valid = 1'b1;
                in_a     = next_a;
                in_b     = next_b;
                in_cin   = 1'b0;
            end
            if (j == bp) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int accepts[$];
        int exp_q[$];
        int got;
        logic [W-1:0] ops_a[2];
        logic [W-1:0] ops_b[2];
        int k;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out", {out_cout, 19'd0, out_sum}, 32'd0);
        check_eq("rst_add", {28'd0, add_cin, add_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(12'h0A5, 12'h05A, 1'b0, 0, 1'b0);
        run_op(12'hFFF, 12'h001, 1'b0, 0, 1'b0);
        run_op(12'hFFF, 12'hFFF, 1'b1, 1, 1'b0);

        // Backpressure with a pending request that must not be taken early
        next_a = 12'h111;
        next_b = 12'h111;
        run_op(12'h123, 12'h456, 1'b0, 3, 1'b1);
        run_op(12'h111, 12'h111, 1'b0, 0, 1'b0);

        // Reset in the second RUN cycle
        in_valid = 1'b1;
        in_a     = 12'h3C7;
        in_b     = 12'h2A5;
        in_cin   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_add", {28'd0, add_cin, add_a} | 32'(add_b), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("abort_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        run_op(12'h7FF, 12'h001, 1'b0, 0, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // Back-to-back: in_valid held, out_ready tied high
        ops_a[0] = 12'h9AB; ops_b[0] = 12'h765;
        ops_a[1] = 12'h0F0; ops_b[1] = 12'hF0F;
        k = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cin    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("b2b_unexpected", 32'd1, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    check_eq("b2b_result", {19'd0, out_cout, out_sum}, 32'(got));
                end
            end
            if (in_ready && in_valid) begin
                in_a = ops_a[k];
                in_b = ops_b[k];
                exp_q.push_back(int'(32'(ops_a[k]) + 32'(ops_b[k]) + 32'd1));
                accepts.push_back(cycle);
                k++;
            end else if (k == 2) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("b2b_accepts", 32'(accepts.size()), 32'd2);
        if (accepts.size() == 2) begin
            check_eq("b2b_spacing", 32'(accepts[1] - accepts[0]), 32'(WORDS + 2));
        end
        check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
